// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU int-to-float issue path.
// The pipeline latency and tag width are fixed here so every FPU block agrees on them.
package fpu_pkg;

  localparam int ITOF_LAT = 3;
  localparam int TAG_W    = 5;

  typedef logic [TAG_W-1:0] fpu_tag_t;

  typedef struct packed {
    logic [31:0] data;
    fpu_tag_t    tag;
  } fpu_resp_t;

  // Number of conversions currently travelling through itof_pipeline.
  function automatic int unsigned count_inflight(input logic [ITOF_LAT-1:0] vld);
    int unsigned n;
    n = 0;
    for (int i = 0; i < ITOF_LAT; i++) begin
      n += int'(vld[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fpu_resp_fifo.sv
// Synchronous result FIFO of fpu_resp_t with an occupancy count.
// Space is guaranteed by the caller's credit scheme; overflow is only asserted.
module fpu_resp_fifo
  import fpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  fpu_resp_t        wdata,
  input  logic             pop,
  output fpu_resp_t        rdata,
  output logic [CNT_W-1:0] count
);

  fpu_resp_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             kill;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    kill     = rst || clr;
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)   wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (kill) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    count_q  <= count_d;
  end

  // NOTE: the storage array is deliberately not reset; rdata is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push && !kill) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!kill) begin
      assert (!(push && !pop_ok && (count_q == CNT_W'(DEPTH))))
        else $error("fpu_resp_fifo overflow");
    end
  end

  assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/itof_issue_ctrl.sv
// Issue/collect wrapper in front of the fixed-latency itof_pipeline: tracks valid+tag
// alongside the data and buffers results in a credit-protected FIFO for writeback.
module itof_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_src,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      itof_a,
  input  logic [31:0]      itof_res,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = CNT_W + 1;

  if (FIFO_DEPTH < ITOF_LAT + 1) begin : g_depth_check
    $error("itof_issue_ctrl: FIFO_DEPTH must be at least ITOF_LAT+1");
  end

  logic [ITOF_LAT-1:0]           vld_sr_q, vld_sr_d;
  fpu_tag_t [ITOF_LAT-1:0]       tag_sr_q, tag_sr_d;
  logic [CNT_W-1:0]              fifo_count;
  logic [SUM_W-1:0]              inflight;
  logic [SUM_W-1:0]              credits_used;
  logic                          acc;
  logic                          push;
  logic                          pop;
  fpu_resp_t                     push_entry;
  fpu_resp_t                     head;

  always_comb begin
    inflight     = SUM_W'(count_inflight(vld_sr_q));
    // Credits use the registered count: a pop in this cycle frees space only next cycle.
    credits_used = SUM_W'(fifo_count) + inflight;
    req_ready    = !rst && !flush && (credits_used < SUM_W'(FIFO_DEPTH));
    acc          = req_valid && req_ready;
    itof_a       = acc ? req_src : '0;

    resp_valid   = (fifo_count != '0);
    pop          = resp_valid && resp_ready && !flush;
    push         = vld_sr_q[ITOF_LAT-1];
    push_entry   = '{data: itof_res, tag: tag_sr_q[ITOF_LAT-1]};

    vld_sr_d     = {vld_sr_q[ITOF_LAT-2:0], acc};
    tag_sr_d     = {tag_sr_q[ITOF_LAT-2:0], req_tag};
    // Killed ops lose their valid bit; their results still leave itof_pipeline but are ignored.
    if (rst || flush) vld_sr_d = '0;
    if (rst)          tag_sr_d = '0;

    resp_data    = head.data;
    resp_tag     = head.tag;
    busy         = (|vld_sr_q) || resp_valid;
  end

  always_ff @(posedge clk) begin
    vld_sr_q <= vld_sr_d;
    tag_sr_q <= tag_sr_d;
  end

  fpu_resp_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_itof_issue_ctrl.sv
// Self-checking bench for itof_issue_ctrl: a behavioural itof_pipeline drives itof_res and a
// transaction-level scoreboard predicts handshakes, response order, latency and busy.
module tb_itof_issue_ctrl;
  import fpu_pkg::*;

  localparam int FIFO_DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_src;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      itof_a;
  logic [31:0]      itof_res;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  itof_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_tag    (req_tag),
    .itof_a     (itof_a),
    .itof_res   (itof_res),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference int32 -> IEEE-754 single, rounding the magnitude half-up.
  function automatic logic [31:0] int_to_float(input logic [31:0] a);
    longint mag;
    longint m;
    int     e;
    logic   s;
    if (a == 32'h0) return 32'h0;
    s   = a[31];
    mag = longint'($signed(a));
    if (mag < 0) mag = -mag;
    e = 31;
    while (((mag >> e) & 64'sd1) == 64'sd0) e--;
    if (e <= 23) begin
      m = mag << (23 - e);
    end else begin
      m = (mag + (64'sd1 << (e - 24))) >> (e - 23);
      if (m >= (64'sd1 << 24)) begin
        m = m >> 1;
        e++;
      end
    end
    return {s, 8'(e + 127), 23'(m)};
  endfunction

  // Behavioural itof_pipeline: result appears ITOF_LAT edges after input_a is sampled.
  logic [31:0] pipe_q [ITOF_LAT];
  always @(posedge clk) begin
    pipe_q[0] <= int_to_float(itof_a);
    for (int k = 1; k < ITOF_LAT; k++) pipe_q[k] <= pipe_q[k-1];
  end
  assign itof_res = pipe_q[ITOF_LAT-1];

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               rdy_cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [31:0]      got_data[$];
  logic [TAG_W-1:0] got_tag[$];
  int               n_assert;
  int               n_fail;
  int               n_acc_obs;
  int               cyc;
  bit               post_reset;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s @cycle %0d: observed 0x%08h expected 0x%08h", name, cyc, obs, exp);
      end
  endtask

  // One clock cycle: check outputs mid-cycle against the scoreboard, then advance it.
  task automatic tick();
    bit   exp_ready, exp_acc, exp_valid, pop_now, kill;
    exp_t e;
    @(negedge clk);
    kill      = rst || flush;
    exp_ready = !rst && !flush && (exp_q.size() < FIFO_DEPTH);
    exp_acc   = exp_ready && req_valid;
    exp_valid = (exp_q.size() != 0) && (exp_q[0].rdy_cyc <= cyc);
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    check("itof_a", itof_a, exp_acc ? req_src : 32'h0);
    check("resp_valid", 32'(resp_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("resp_data", resp_data, exp_q[0].data);
      check("resp_tag", 32'(resp_tag), 32'(exp_q[0].tag));
    end
    if (post_reset) begin
      check("reset_resp_data", resp_data, 32'h0);
      check("reset_resp_tag", 32'(resp_tag), 32'h0);
    end
    check("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (req_valid && req_ready) n_acc_obs++;
    if (resp_valid && resp_ready && !kill) begin
      got_data.push_back(resp_data);
      got_tag.push_back(resp_tag);
    end
    pop_now = exp_valid && resp_ready;
    e.data    = int_to_float(req_src);
    e.tag     = req_tag;
    e.rdy_cyc = cyc + ITOF_LAT + 1;
    @(posedge clk);
    #1;
    if (kill) begin
      exp_q.delete();
    end else begin
      if (pop_now) void'(exp_q.pop_front());
      if (exp_acc) exp_q.push_back(e);
    end
    post_reset = rst;
    cyc++;
  endtask

  task automatic issue(input logic [31:0] src, input logic [TAG_W-1:0] tag);
    req_valid = 1'b1;
    req_src   = src;
    req_tag   = tag;
    tick();
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    req_src   = 32'h0;
    repeat (n) tick();
  endtask

  task automatic check_got(input int idx, input logic [31:0] d, input logic [TAG_W-1:0] t);
    if (idx < got_data.size()) begin
      check("got_data", got_data[idx], d);
      check("got_tag", 32'(got_tag[idx]), 32'(t));
    end else begin
      check("got_count", 32'(got_data.size()), 32'(idx + 1));
    end
  endtask

  task automatic clear_got();
    got_data.delete();
    got_tag.delete();
  endtask

  initial begin
    int k;
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_src    = 32'h0;
    req_tag    = '0;
    resp_ready = 1'b0;
    n_assert   = 0;
    n_fail     = 0;
    n_acc_obs  = 0;
    cyc        = 0;
    post_reset = 1'b1;
    @(posedge clk);
    #1;
    tick();
    rst = 1'b0;

    // Back-to-back stream with writeback always ready.
    resp_ready = 1'b1;
    clear_got();
    issue(32'd1, 5'd1);
    issue(32'hFFFF_FFFF, 5'd2);
    issue(32'd3, 5'd3);
    issue(32'd0, 5'd4);
    idle(8);
    check_got(0, 32'h3F80_0000, 5'd1);
    check_got(1, 32'hBF80_0000, 5'd2);
    check_got(2, 32'h4040_0000, 5'd3);
    check_got(3, 32'h0000_0000, 5'd4);

    // Integer extremes.
    clear_got();
    issue(32'h7FFF_FFFF, 5'd7);
    issue(32'h8000_0000, 5'd8);
    idle(8);
    check_got(0, 32'h4F00_0000, 5'd7);
    check_got(1, 32'hCF00_0000, 5'd8);

    // Back-pressure: requests held for 8 cycles, only FIFO_DEPTH accepted.
    clear_got();
    resp_ready = 1'b0;
    n_acc_obs  = 0;
    for (int i = 0; i < 8; i++) issue(32'(100 * (i + 1)), TAG_W'(10 + i));
    check("bp_accepted", 32'(n_acc_obs), 32'(FIFO_DEPTH));
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    idle(6);
    for (int i = 0; i < 4; i++) check_got(i, int_to_float(32'(100 * (i + 1))), TAG_W'(10 + i));
    check("bp_resp_count", 32'(got_data.size()), 32'd4);
    issue(32'd42, 5'd20);
    idle(6);

    // Full FIFO: pop and result arrival overlap while requests keep coming.
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'(-(i + 5)), TAG_W'(i + 1));
    idle(2);
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) issue(32'(1000 + i), TAG_W'(i + 16));
    idle(10);

    // Flush with two ops in the pipe and two in the FIFO.
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(32'(7 + i), TAG_W'(i + 24));
    idle(1);
    clear_got();
    flush = 1'b1;
    tick();
    flush      = 1'b0;
    resp_ready = 1'b1;
    idle(8);
    check("flush_no_resp", 32'(got_data.size()), 32'd0);

    // Reset while operations are in flight, then one clean op.
    issue(32'd11, 5'd1);
    issue(32'd12, 5'd2);
    issue(32'd13, 5'd3);
    req_valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    clear_got();
    issue(32'h0000_1234, 5'd21);
    idle(6);
    check_got(0, 32'h4591_A000, 5'd21);
    check("reset_resp_count", 32'(got_data.size()), 32'd1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      req_valid  = ($urandom_range(0, 9) < 7);
      req_src    = $urandom;
      req_tag    = TAG_W'($urandom);
      resp_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush      = 1'b0;
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    check("drain_idle", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
